// File: rtl/rv_inflight_scoreboard.sv
// In-order in-flight destination-register tracker: records rd at issue, drops it at retire,
// and reports RAW busy/age/load-use for the decode sources. Optional retire check: SCOREBOARD_CHECK_EN.
module rv_inflight_scoreboard #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic          issue_ready,
    input  logic          issue_wen,
    input  logic          issue_load,
    input  logic [4:0]    issue_rd,
    input  logic [4:0]    rs1_D,
    input  logic [4:0]    rs2_D,
    input  logic          use_rs2,
    input  logic          wb_valid,
    input  logic [4:0]    wb_rd,
    input  logic          flush,
    input  logic [AW:0]   flush_keep,
    output logic          busy_rs1,
    output logic          busy_rs2,
    output logic [AW-1:0] age_rs1,
    output logic [AW-1:0] age_rs2,
    output logic          stall_D,
    output logic          full,
    output logic [AW:0]   count,
    output logic          err
);
    logic [4:0]       rd_mem [DEPTH];
    logic [DEPTH-1:0] wen_mem;
    logic [DEPTH-1:0] load_mem;

    logic [AW-1:0] head_reg, head_next;
    logic [AW-1:0] tail_reg, tail_next;
    logic [AW:0]   count_reg, count_next;
    logic [AW:0]   count_after_pop;

    logic [DEPTH-1:0] hit1, hit2;
    logic [AW-1:0]    newest_idx;
    logic             load_use;
    logic             push, pop;

    // Slot gi is the entry gi places behind the newest one; it is live while gi < count.
    // Validity is derived from count, so emptying the queue invalidates every entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [AW-1:0] idx;
        logic          live;
        assign idx  = tail_reg - AW'(gi + 1);
        assign live = (AW+1)'(gi) < count_reg;
        assign hit1[gi] = live && wen_mem[idx] && (rd_mem[idx] == rs1_D) && (rs1_D != 5'd0);
        assign hit2[gi] = live && use_rs2 && wen_mem[idx] && (rd_mem[idx] == rs2_D)
                          && (rs2_D != 5'd0);
    end

    always_comb begin
        age_rs1 = '0;
        age_rs2 = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit1[k]) age_rs1 = AW'(k);
            if (hit2[k]) age_rs2 = AW'(k);
        end
    end

    assign busy_rs1   = |hit1;
    assign busy_rs2   = |hit2;
    assign newest_idx = tail_reg - AW'(1);
    // A hit at slot 0 is necessarily the youngest match for that source.
    assign load_use   = (hit1[0] || hit2[0]) && load_mem[newest_idx];
    assign full       = (count_reg == (AW+1)'(DEPTH));
    assign stall_D    = full || load_use;
    assign count      = count_reg;

    assign pop  = wb_valid && (count_reg != '0);
    assign push = issue_valid && issue_ready && !stall_D && !flush;

    always_comb begin
        head_next       = head_reg + AW'(pop);
        count_after_pop = count_reg - (AW+1)'(pop);
        count_next      = count_after_pop + (AW+1)'(push);
        tail_next       = tail_reg + AW'(push);
        if (flush) begin
            count_next = (flush_keep < count_after_pop) ? flush_keep : count_after_pop;
            tail_next  = head_next + count_next[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry payload needs no reset: liveness comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail_reg]   <= issue_rd;
            wen_mem[tail_reg]  <= issue_wen;
            load_mem[tail_reg] <= issue_load;
        end
    end

`ifdef SCOREBOARD_CHECK_EN
    logic err_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if ((wb_valid && (count_reg == '0)) ||
                     (pop && wen_mem[head_reg] && (rd_mem[head_reg] != wb_rd))) begin
            err_reg <= 1'b1;
        end
    end
    assign err = err_reg;
`else
    logic unused_wb_rd;
    assign unused_wb_rd = ^wb_rd;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rv_inflight_scoreboard.sv
// Self-checking bench for rv_inflight_scoreboard: a queue-based reference model predicts every
// output each cycle; directed steps follow the decode hazard scenarios, then a random phase.
module tb_rv_inflight_scoreboard;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef SCOREBOARD_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid, issue_ready, issue_wen, issue_load;
    logic [4:0]    issue_rd, rs1_D, rs2_D, wb_rd;
    logic          use_rs2, wb_valid, flush;
    logic [AW:0]   flush_keep;
    logic          busy_rs1, busy_rs2, stall_D, full, err;
    logic [AW-1:0] age_rs1, age_rs2;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    rv_inflight_scoreboard #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_wen(issue_wen),
        .issue_load(issue_load), .issue_rd(issue_rd),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs2(use_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .flush(flush), .flush_keep(flush_keep),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .age_rs1(age_rs1), .age_rs2(age_rs2),
        .stall_D(stall_D), .full(full), .count(count), .err(err)
    );

    typedef struct { logic [4:0] rd; logic wen; logic load; } ent_t;
    typedef struct {
        logic b1; logic [AW-1:0] a1; logic b2; logic [AW-1:0] a2;
        logic st; logic fu; logic [AW:0] cnt; logic er;
    } exp_t;

    ent_t mq[$];
    exp_t exp_q[$];
    logic m_err;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t got;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    // Predict from model state + present inputs, compare, then advance the model and the clock.
    task automatic step();
        exp_t e, x;
        int   n, a1, a2;
        bit   f1, f2, lu, st, pop, push;
        #2;
        n = mq.size(); f1 = 0; f2 = 0; a1 = 0; a2 = 0;
        for (int k = 0; k < n; k++) begin
            if (!f1 && mq[n-1-k].wen && mq[n-1-k].rd == rs1_D && rs1_D != 0) begin
                f1 = 1; a1 = k;
            end
            if (!f2 && use_rs2 && mq[n-1-k].wen && mq[n-1-k].rd == rs2_D && rs2_D != 0) begin
                f2 = 1; a2 = k;
            end
        end
        lu = (n > 0) && mq[n-1].load && ((f1 && a1 == 0) || (f2 && a2 == 0));
        st = (n == DEPTH) || lu;
        e.b1 = f1; e.a1 = AW'(a1); e.b2 = f2; e.a2 = AW'(a2);
        e.st = st; e.fu = (n == DEPTH); e.cnt = (AW+1)'(n); e.er = m_err;
        exp_q.push_back(e);

        got.b1 = busy_rs1; got.a1 = age_rs1; got.b2 = busy_rs2; got.a2 = age_rs2;
        got.st = stall_D; got.fu = full; got.cnt = count; got.er = err;
        x = exp_q.pop_front();
        check("busy_rs1", got.b1, x.b1);
        check("age_rs1",  got.a1, x.a1);
        check("busy_rs2", got.b2, x.b2);
        check("age_rs2",  got.a2, x.a2);
        check("stall_D",  got.st, x.st);
        check("full",     got.fu, x.fu);
        check("count",    got.cnt, x.cnt);
        check("err",      got.er, x.er);

        pop  = wb_valid && n > 0;
        push = issue_valid && issue_ready && !st && !flush;
`ifdef SCOREBOARD_CHECK_EN
        if (wb_valid && n == 0) m_err = 1'b1;
        if (pop && mq[0].wen && mq[0].rd != wb_rd) m_err = 1'b1;
`endif
        $display("cyc %0d issue=%0b rd=%0d push=%0b pop=%0b flush=%0b keep=%0d count=%0d stall=%0b",
                 cyc, issue_valid, issue_rd, push, pop, flush, flush_keep, count, stall_D);
        if (pop) void'(mq.pop_front());
        if (flush) begin
            while (mq.size() > int'(flush_keep)) void'(mq.pop_back());
        end else if (push) begin
            mq.push_back('{rd: issue_rd, wen: issue_wen, load: issue_load});
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic wen, input logic ld, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic ur,
                         input logic wbv, input logic [4:0] wbr,
                         input logic fl, input logic [AW:0] keep);
        issue_valid = iv; issue_ready = 1'b1; issue_wen = wen; issue_load = ld; issue_rd = rd;
        rs1_D = r1; rs2_D = r2; use_rs2 = ur; wb_valid = wbv; wb_rd = wbr;
        flush = fl; flush_keep = keep;
        step();
    endtask

    // Reset lands while a push, retire and flush are all requested.
    task automatic do_reset();
        rst = 1'b1;
        issue_valid = 1'b1; issue_ready = 1'b1; issue_wen = 1'b1; issue_load = 1'b0;
        issue_rd = 5'd6; rs1_D = 5'd0; rs2_D = 5'd0; use_rs2 = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd0; flush = 1'b1; flush_keep = 3'd2;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_err = 1'b0;
    endtask

    initial begin
        m_err = 1'b0;
        do_reset();
        drive(0,0,0,0, 0,0,0, 0,0, 0,0);
        check("rst_count", got.cnt, 0);

        // ALU writer, visible to decode the next cycle.
        drive(1,1,0,5, 0,0,0, 0,0, 0,0);
        drive(0,0,0,0, 5,0,0, 0,0, 0,0);
        check("alu_busy", got.b1, 1);
        check("alu_stall", got.st, 0);
        check("alu_count", got.cnt, 1);

        // Load-use on rs2, then relieved by an intervening bubble.
        drive(1,1,1,7, 0,0,0, 0,0, 0,0);
        drive(1,1,0,8, 0,7,1, 0,0, 0,0);
        check("lu_stall", got.st, 1);
        drive(1,0,0,0, 0,0,0, 0,0, 0,0);
        drive(0,0,0,0, 0,7,1, 0,0, 0,0);
        check("lu_age", got.a2, 1);
        check("lu_clear", got.st, 0);
        drive(0,0,0,0, 0,0,0, 1,5, 0,0);
        drive(0,0,0,0, 0,0,0, 1,7, 0,0);
        drive(0,0,0,0, 0,0,0, 1,0, 0,0);

        // Duplicate rd: youngest producer wins; retire removes the older one first.
        drive(1,1,0,3, 0,0,0, 0,0, 0,0);
        drive(1,1,0,3, 0,0,0, 0,0, 0,0);
        drive(1,1,0,4, 0,0,0, 0,0, 0,0);
        drive(0,0,0,0, 3,0,0, 1,3, 0,0);
        check("dup_age", got.a1, 1);
        check("dup_same_cycle_busy", got.b1, 1);
        drive(0,0,0,0, 3,0,0, 0,0, 0,0);
        check("dup_count2", got.cnt, 2);
        check("dup_busy_young", got.b1, 1);
        drive(0,0,0,0, 3,0,0, 1,3, 0,0);
        drive(0,0,0,0, 3,0,0, 0,0, 0,0);
        check("dup_gone", got.b1, 0);
        drive(0,0,0,0, 0,0,0, 1,4, 0,0);

        // Fill to full, blocked issue, retire with simultaneous blocked issue.
        for (int i = 1; i <= DEPTH; i++) drive(1,1,0,5'(i), 0,0,0, 0,0, 0,0);
        drive(1,1,0,9, 0,0,0, 0,0, 0,0);
        check("full_flag", got.fu, 1);
        check("full_stall", got.st, 1);
        drive(1,1,0,9, 0,0,0, 1,1, 0,0);
        check("full_blocked", got.cnt, 4);
        drive(0,0,0,0, 9,0,0, 0,0, 0,0);
        check("after_pop_count", got.cnt, 3);
        check("after_pop_full", got.fu, 0);
        check("blocked_not_rec", got.b1, 0);

        // Flush with retire and issue in the same cycle: keep one of the two survivors.
        drive(1,1,0,12, 0,0,0, 1,2, 1,1);
        drive(0,0,0,0, 3,12,1, 0,0, 0,0);
        check("flush_count", got.cnt, 1);
        check("flush_kept", got.b1, 1);
        check("flush_drop_issue", got.b2, 0);
        drive(0,0,0,0, 0,0,0, 0,0, 1,0);
        drive(0,0,0,0, 3,0,0, 0,0, 0,0);
        check("flush_empty", got.cnt, 0);

        // Retire-order mismatch, then a retire on an empty queue.
        drive(1,1,0,9, 0,0,0, 0,0, 0,0);
        drive(0,0,0,0, 0,0,0, 1,10, 0,0);
        drive(0,0,0,0, 0,0,0, 0,0, 0,0);
        drive(0,0,0,0, 0,0,0, 0,0, 0,0);
        check("err_sticky", got.er, CHK);
        drive(0,0,0,0, 0,0,0, 1,0, 0,0);
        drive(0,0,0,0, 0,0,0, 0,0, 0,0);
        check("empty_pop_count", got.cnt, 0);

        // Reset in the middle of traffic.
        drive(1,1,0,6, 0,0,0, 0,0, 0,0);
        drive(1,1,1,6, 0,0,0, 0,0, 0,0);
        do_reset();
        drive(0,0,0,0, 6,6,1, 0,0, 0,0);
        check("midrst_count", got.cnt, 0);
        check("midrst_busy", got.b1, 0);

        for (int i = 0; i < 400; i++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_ready = ($urandom_range(0, 4) != 0);
            issue_wen   = ($urandom_range(0, 4) != 0);
            issue_load  = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1_D       = 5'($urandom_range(0, 7));
            rs2_D       = 5'($urandom_range(0, 7));
            use_rs2     = 1'($urandom_range(0, 1));
            wb_valid    = ($urandom_range(0, 2) == 0);
            wb_rd       = (mq.size() > 0) ? mq[0].rd : 5'd0;
            flush       = ($urandom_range(0, 15) == 0);
            flush_keep  = (AW+1)'($urandom_range(0, DEPTH));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
